// File: rtl/data_register.sv
// data_register: parallel-load register with write enable and async active-high reset.
// Optional stored even-parity bit when DATA_REGISTER_PARITY_EN is defined.
`default_nettype none

`ifndef DATA_BUS_LEN
`define DATA_BUS_LEN 8
`endif

module data_register #(
  parameter int                      DATA_WIDTH  = `DATA_BUS_LEN,
  parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] INPUT,
  input  logic                  WR,
`ifdef DATA_REGISTER_PARITY_EN
  output logic                  PARITY,
`endif
  output logic [DATA_WIDTH-1:0] OUTPUT
);

  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q <= RESET_VALUE;
    end else if (WR) begin
      data_q <= INPUT;
    end
  end

  assign OUTPUT = data_q;

`ifdef DATA_REGISTER_PARITY_EN
  // Parity is captured alongside the data so it can be cross-checked against ^OUTPUT.
  logic parity_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      parity_q <= ^RESET_VALUE;
    end else if (WR) begin
      parity_q <= ^INPUT;
    end
  end

  assign PARITY = parity_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_register.sv
// Self-checking bench for data_register: directed cases followed by randomized traffic.
`default_nettype none

module tb_data_register;

  logic       CLK;
  logic       RST;
  logic [7:0] INPUT;
  logic       WR;
  logic [7:0] OUTPUT;
`ifdef DATA_REGISTER_PARITY_EN
  logic       PARITY;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference: the register holds whatever was last written since reset, else zero.
  logic [7:0] model;

  data_register dut (
    .CLK    (CLK),
    .RST    (RST),
    .INPUT  (INPUT),
    .WR     (WR),
`ifdef DATA_REGISTER_PARITY_EN
    .PARITY (PARITY),
`endif
    .OUTPUT (OUTPUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_out(input string tag, input logic [7:0] expected);
    checks++;
    assert (OUTPUT === expected)
    else begin
      failures++;
      $error("FAIL %s: OUTPUT=%h expected=%h", tag, OUTPUT, expected);
    end
`ifdef DATA_REGISTER_PARITY_EN
    checks++;
    assert (PARITY === ^expected)
    else begin
      failures++;
      $error("FAIL %s_parity: PARITY=%b expected=%b", tag, PARITY, ^expected);
    end
`endif
  endtask

  // Drive inputs away from the edge, clock once, then sample on the falling edge.
  task automatic cycle(input logic w, input logic [7:0] d, input string tag);
    WR    = w;
    INPUT = d;
    @(posedge CLK);
    if (w && !RST) model = d;
    if (RST) model = 8'h00;
    @(negedge CLK);
    check_out(tag, model);
  endtask

  initial begin
    RST   = 1'b1;
    WR    = 1'b0;
    INPUT = 8'h00;
    model = 8'h00;
    @(negedge CLK);
    check_out("reset_held", 8'h00);
    RST = 1'b0;
    cycle(1'b0, 8'h00, "after_reset");

    cycle(1'b1, 8'hA5, "write_a5");
    cycle(1'b0, 8'h00, "hold_a5");
    cycle(1'b1, 8'h3C, "write_3c");
    cycle(1'b0, 8'h3C, "hold_3c");
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'hFF, "ignore_ff");
    check_out("still_3c", 8'h3C);

    // Asynchronous reset between edges must clear without a clock edge.
    #2 RST = 1'b1;
    #1 model = 8'h00;
    check_out("async_reset", 8'h00);
    @(negedge CLK);
    cycle(1'b1, 8'h55, "reset_beats_write");
    RST = 1'b0;
    cycle(1'b0, 8'h55, "after_release");

`ifdef DATA_REGISTER_PARITY_EN
    cycle(1'b1, 8'hA5, "par_a5");
    cycle(1'b1, 8'h07, "par_07");
    RST = 1'b1;
    cycle(1'b0, 8'h00, "par_reset");
    RST = 1'b0;
`endif

    cycle(1'b1, 8'hFF, "write_ff");
    cycle(1'b1, 8'h00, "b2b_00");
    cycle(1'b1, 8'h81, "b2b_81");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        #($urandom_range(1, 3)) RST = 1'b1;
        #1 model = 8'h00;
        check_out("rand_async_reset", model);
        @(negedge CLK);
        cycle(1'(($urandom >> 3) & 1), 8'($urandom), "rand_in_reset");
        RST = 1'b0;
      end else begin
        cycle(1'(($urandom >> 5) & 1), 8'($urandom), "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
